// File: rtl/vcve2_vrf_wpack.sv
// Vector register file write packer: packs SEW-wide result elements little-endian
// into 32-bit VRF words and issues byte-enabled word writes across the register group.
module vcve2_vrf_wpack #(
    parameter  int VLEN = 128,
    localparam int WPR  = VLEN / 32,
    localparam int AW   = $clog2(32 * WPR),
    localparam int VLW  = $clog2(VLEN) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [4:0]    vd_i,
    input  logic [2:0]    vsew_i,
    input  logic [VLW-1:0] vl_i,
    output logic          busy_o,
    input  logic          elem_valid_i,
    input  logic [31:0]   elem_data_i,
    output logic          elem_ready_o,
    output logic          vrf_we_o,
    output logic [AW-1:0] vrf_waddr_o,
    output logic [31:0]   vrf_wdata_o,
    output logic [3:0]    vrf_be_o,
    input  logic          vrf_gnt_i,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     vd_q, vd_d;
    logic [1:0]     sew_q, sew_d;
    logic [VLW-1:0] vl_q, vl_d;
    logic [VLW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  widx_q, widx_d;
    logic [31:0]    buf_q, buf_d;
    logic [3:0]     be_q, be_d;
    logic           err_q, err_d;
    logic           word_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vd_q    <= '0;
            sew_q   <= '0;
            vl_q    <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            buf_q   <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vd_q    <= vd_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vd_d         = vd_q;
        sew_d        = sew_q;
        vl_d         = vl_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        buf_d        = buf_q;
        be_d         = be_q;
        err_d        = err_q;
        elem_ready_o = 1'b0;
        vrf_we_o     = 1'b0;
        done_o       = 1'b0;
        word_full    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    vd_d   = vd_i;
                    sew_d  = vsew_i[1:0];
                    vl_d   = vl_i;
                    err_d  = (vsew_i > 3'd2);
                    cnt_d  = '0;
                    widx_d = '0;
                    buf_d  = '0;
                    be_d   = '0;
                    if ((vsew_i > 3'd2) || (vl_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                elem_ready_o = 1'b1;
                if (elem_valid_i) begin
                    // Slot within the word comes from the low bits of the element count.
                    case (sew_q)
                        2'd0: begin
                            buf_d[{cnt_q[1:0], 3'b000} +: 8] = elem_data_i[7:0];
                            be_d[cnt_q[1:0]]                 = 1'b1;
                            word_full                        = (cnt_q[1:0] == 2'd3);
                        end
                        2'd1: begin
                            buf_d[{cnt_q[0], 4'b0000} +: 16] = elem_data_i[15:0];
                            be_d[{cnt_q[0], 1'b0} +: 2]      = 2'b11;
                            word_full                        = cnt_q[0];
                        end
                        default: begin
                            buf_d     = elem_data_i;
                            be_d      = 4'hF;
                            word_full = 1'b1;
                        end
                    endcase
                    cnt_d = cnt_q + 1'b1;
                    if (word_full || (cnt_d == vl_q)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                vrf_we_o = 1'b1;
                if (vrf_gnt_i) begin
                    widx_d  = widx_q + 1'b1;
                    buf_d   = '0;
                    be_d    = '0;
                    state_d = (cnt_q == vl_q) ? DONE : FILL;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register group wraps modulo the VRF size, so v31 continues into v0.
    assign vrf_waddr_o = (state_q == WRITE) ? (AW'(vd_q) * AW'(WPR) + widx_q) : '0;
    assign vrf_wdata_o = (state_q == WRITE) ? buf_q : '0;
    assign vrf_be_o    = (state_q == WRITE) ? be_q : '0;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_vcve2_vrf_wpack.sv
// Self-checking bench for vcve2_vrf_wpack: table of write-packing transactions
// plus hand sequences for reset-in-write and post-reset recovery.
module tb_vcve2_vrf_wpack;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  vd_i;
    logic [2:0]  vsew_i;
    logic [7:0]  vl_i;
    logic        busy_o;
    logic        elem_valid_i;
    logic [31:0] elem_data_i;
    logic        elem_ready_o;
    logic        vrf_we_o;
    logic [6:0]  vrf_waddr_o;
    logic [31:0] vrf_wdata_o;
    logic [3:0]  vrf_be_o;
    logic        vrf_gnt_i;
    logic        done_o;
    logic        err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [4:0]        vd;
        logic [2:0]        vsew;
        logic [7:0]        vl;
        int                delay;
        bit                restart;
        bit                err;
        int                nw;
        logic [7:0][31:0]  elems;
        logic [7:0][6:0]   addr;
        logic [7:0][31:0]  data;
        logic [7:0][3:0]   be;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    vcve2_vrf_wpack #(.VLEN(128)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .vd_i         (vd_i),
        .vsew_i       (vsew_i),
        .vl_i         (vl_i),
        .busy_o       (busy_o),
        .elem_valid_i (elem_valid_i),
        .elem_data_i  (elem_data_i),
        .elem_ready_o (elem_ready_o),
        .vrf_we_o     (vrf_we_o),
        .vrf_waddr_o  (vrf_waddr_o),
        .vrf_wdata_o  (vrf_wdata_o),
        .vrf_be_o     (vrf_be_o),
        .vrf_gnt_i    (vrf_gnt_i),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_vec(input int n, input logic [4:0] vd, input logic [2:0] vsew, input logic [7:0] vl,
                           input int delay, input bit restart, input bit err);
        vecs[n]         = '0;
        vecs[n].vd      = vd;
        vecs[n].vsew    = vsew;
        vecs[n].vl      = vl;
        vecs[n].delay   = delay;
        vecs[n].restart = restart;
        vecs[n].err     = err;
    endtask

    task automatic add_write(input int n, input logic [6:0] addr, input logic [31:0] data, input logic [3:0] be);
        vecs[n].addr[vecs[n].nw] = addr;
        vecs[n].data[vecs[n].nw] = data;
        vecs[n].be[vecs[n].nw]   = be;
        vecs[n].nw               = vecs[n].nw + 1;
    endtask

    task automatic fill_table();
        set_vec(0, 5'd2, 3'b000, 8'd5, 0, 1'b0, 1'b0);
        vecs[0].elems = {32'h0, 32'h0, 32'h0, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11};
        add_write(0, 7'd8, 32'h14131211, 4'b1111);
        add_write(0, 7'd9, 32'h00000015, 4'b0001);

        set_vec(1, 5'd0, 3'b010, 8'd3, 2, 1'b0, 1'b0);
        vecs[1].elems = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        add_write(1, 7'd0, 32'hDEADBEEF, 4'b1111);
        add_write(1, 7'd1, 32'h01234567, 4'b1111);
        add_write(1, 7'd2, 32'h89ABCDEF, 4'b1111);

        set_vec(2, 5'd6, 3'b001, 8'd0, 0, 1'b0, 1'b0);

        set_vec(3, 5'd3, 3'b001, 8'd3, 1, 1'b0, 1'b0);
        vecs[3].elems = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000CCCC, 32'hFFFFBBBB, 32'h1234AAAA};
        add_write(3, 7'd12, 32'hBBBBAAAA, 4'b1111);
        add_write(3, 7'd13, 32'h0000CCCC, 4'b0011);

        set_vec(4, 5'd7, 3'b011, 8'd4, 0, 1'b0, 1'b1);

        set_vec(5, 5'd31, 3'b010, 8'd8, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vecs[5].elems[i] = 32'h10000000 + 32'(i);
            add_write(5, 7'((124 + i) % 128), 32'h10000000 + 32'(i), 4'b1111);
        end

        set_vec(6, 5'd5, 3'b000, 8'd6, 1, 1'b0, 1'b0);
        vecs[6].elems = {32'h0, 32'h0, 32'hFFFFFF06, 32'hFFFFFF05, 32'hFFFFFF04, 32'hFFFFFF03, 32'hFFFFFF02, 32'hFFFFFF01};
        add_write(6, 7'd20, 32'h04030201, 4'b1111);
        add_write(6, 7'd21, 32'h00000605, 4'b0011);

        set_vec(7, 5'd1, 3'b111, 8'd0, 0, 1'b0, 1'b1);

        // A second start is pulsed mid-transaction and must not disturb this one.
        set_vec(8, 5'd4, 3'b010, 8'd2, 0, 1'b1, 1'b0);
        vecs[8].elems = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0002, 32'hCAFE0001};
        add_write(8, 7'd16, 32'hCAFE0001, 4'b1111);
        add_write(8, 7'd17, 32'hCAFE0002, 4'b1111);
    endtask

    task automatic apply_stimulus(input int n);
        vec_t        v;
        int          cyc, e, w, wait_cnt;
        bit          done_seen, prev_wait;
        logic [6:0]  pa;
        logic [31:0] pd;
        logic [3:0]  pb;
        v         = vecs[n];
        cyc       = 0;
        e         = 0;
        w         = 0;
        wait_cnt  = 0;
        done_seen = 1'b0;
        prev_wait = 1'b0;
        pa        = '0;
        pd        = '0;
        pb        = '0;
        @(negedge clk_i);
        start_i = 1'b1;
        vd_i    = v.vd;
        vsew_i  = v.vsew;
        vl_i    = v.vl;
        while (!done_seen && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            start_i      = 1'b0;
            elem_valid_i = 1'b0;
            vrf_gnt_i    = 1'b0;
            if (v.restart && cyc == 2) begin
                start_i = 1'b1;
                vd_i    = 5'd9;
                vsew_i  = 3'b000;
                vl_i    = 8'd1;
            end
            if (cyc == 1) check_output($sformatf("v%0d_busy_after_start", n), 64'(busy_o), 64'd1);
            if (done_o) begin
                done_seen = 1'b1;
                check_output($sformatf("v%0d_err", n), 64'(err_o), 64'(v.err));
                check_output($sformatf("v%0d_write_count", n), 64'(w), 64'(v.nw));
                check_output($sformatf("v%0d_elems_accepted", n), 64'(e), v.err ? 64'd0 : 64'(v.vl));
                if (v.err || v.vl == 8'd0) check_output($sformatf("v%0d_done_latency", n), 64'(cyc), 64'd1);
            end else if (vrf_we_o) begin
                check_output($sformatf("v%0d_ready_in_write", n), 64'(elem_ready_o), 64'd0);
                if (prev_wait) begin
                    check_output($sformatf("v%0d_stall_stable", n), {25'd0, vrf_waddr_o, vrf_wdata_o},
                                 {25'd0, pa, pd});
                    check_output($sformatf("v%0d_stall_be_stable", n), 64'(vrf_be_o), 64'(pb));
                end
                if (wait_cnt == v.delay) begin
                    vrf_gnt_i = 1'b1;
                    if (w < v.nw) begin
                        check_output($sformatf("v%0d_w%0d_addr", n, w), 64'(vrf_waddr_o), 64'(v.addr[w]));
                        check_output($sformatf("v%0d_w%0d_data", n, w), 64'(vrf_wdata_o), 64'(v.data[w]));
                        check_output($sformatf("v%0d_w%0d_be", n, w), 64'(vrf_be_o), 64'(v.be[w]));
                    end else begin
                        check_output($sformatf("v%0d_extra_write", n), 64'(w + 1), 64'(v.nw));
                    end
                    w++;
                    wait_cnt  = 0;
                    prev_wait = 1'b0;
                end else begin
                    wait_cnt++;
                    prev_wait = 1'b1;
                    pa        = vrf_waddr_o;
                    pd        = vrf_wdata_o;
                    pb        = vrf_be_o;
                end
            end else begin
                prev_wait = 1'b0;
                if (elem_ready_o) begin
                    elem_valid_i = 1'b1;
                    elem_data_i  = (e < 8) ? v.elems[e] : 32'hEEEEEEEE;
                    e++;
                end
            end
        end
        if (!done_seen) check_output($sformatf("v%0d_done_timeout", n), 64'd0, 64'd1);
        start_i      = 1'b0;
        elem_valid_i = 1'b0;
        vrf_gnt_i    = 1'b0;
        @(negedge clk_i);
        check_output($sformatf("v%0d_busy_after_done", n), {62'd0, busy_o, done_o}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ctrl"}, {59'd0, busy_o, elem_ready_o, vrf_we_o, done_o, err_o}, 64'd0);
        check_output({tag, "_wport"}, {21'd0, vrf_waddr_o, vrf_wdata_o, vrf_be_o}, 64'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        vd_i         = '0;
        vsew_i       = '0;
        vl_i         = '0;
        elem_valid_i = 1'b0;
        elem_data_i  = '0;
        vrf_gnt_i    = 1'b0;
        fill_table();
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_state");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("idle_after_reset");

        for (int n = 0; n < NVEC; n++) begin
            apply_stimulus(n);
        end

        // Reset while a write is pending with grant held low.
        @(negedge clk_i);
        start_i = 1'b1;
        vd_i    = 5'd0;
        vsew_i  = 3'b010;
        vl_i    = 8'd2;
        @(negedge clk_i);
        start_i      = 1'b0;
        elem_valid_i = 1'b1;
        elem_data_i  = 32'h55555555;
        @(negedge clk_i);
        elem_valid_i = 1'b0;
        check_output("rst_mid_we_before", 64'(vrf_we_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("rst_mid_after");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_output("rst_mid_no_write", {62'd0, vrf_we_o, busy_o}, 64'd0);

        apply_stimulus(0);
        apply_stimulus(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vcve2_vrf_wpack.md
# vcve2_vrf_wpack

Vector register file write packer for the vector extension datapath. It accepts a stream of SEW-wide result elements from the vector execution path, packs them little-endian into 32-bit VRF words, and issues word writes with byte enables across the destination register group. It is the write-side counterpart of the VRF read sequencer (IDLE/START/READ/WAITBUS/WRITE flow) and sits between the vector ALU/load path and the VRF write port.

## Interface

- VLEN, 128: vector register length in bits; multiple of 32, power of two.
- WPR, VLEN/32 (derived localparam): 32-bit words per vector register.
- AW, $clog2(32*WPR) (derived localparam): VRF word address width (7 for VLEN=128).
- VLW, $clog2(VLEN)+1 (derived localparam): vl width; max vl = VLEN (SEW8, LMUL8).

- clk_i  in  1  clock; single clock domain, all state on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle request; samples vd_i, vsew_i, vl_i.
- vd_i  in  5  destination base vector register.
- vsew_i  in  3  element width, vsew_e encoding (VSEW_8/16/32).
- vl_i  in  VLW  number of elements to write.
- busy_o  out  1  high from accepted start until done_o cycle inclusive.
- elem_valid_i  in  1  element offered.
- elem_data_i  in  32  element; only low SEW bits used.
- elem_ready_o  out  1  element accepted when valid & ready.
- vrf_we_o  out  1  word write request.
- vrf_waddr_o  out  AW  word address.
- vrf_wdata_o  out  32  packed word; unfilled bytes zero.
- vrf_be_o  out  4  byte enables.
- vrf_gnt_i  in  1  write accepted this cycle (when vrf_we_o high).
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid only with done_o; high for invalid vsew_i.

## Operation

- States: IDLE, FILL, WRITE, DONE.
- IDLE: start_i=1 captures config, clears buffer, word index, element count. vsew_i not in {000,001,010} → DONE with err latched. vl_i=0 → DONE. Else → FILL. start_i outside IDLE is ignored.
- FILL: elem_ready_o=1. Accepted element k (k counted from 0) written into byte offset (k mod EPW)*SB, SB=1/2/4, EPW=4/2/1; corresponding be bits set. Transition to WRITE when the word is full (EPW elements) or element count reaches vl.
- WRITE: vrf_we_o=1; waddr=(vd*WPR + word_idx) mod 2^AW (group wraps past v31 to v0); wdata/be held stable until vrf_gnt_i. On grant: word_idx+1, buffer and be cleared; if count==vl → DONE, else → FILL. elem_ready_o=0.
- DONE: done_o=1, err_o=latched err, → IDLE.
- Tail bytes of a partial final word are not enabled (tail undisturbed); the bench checks be, not memory contents.
- No vl vs VLMAX check: vl_i up to VLEN accepted as given.

## Timing

- Reset values: state IDLE; busy_o, elem_ready_o, vrf_we_o, done_o, err_o = 0; vrf_waddr_o, vrf_wdata_o, vrf_be_o = 0; buffer, counters cleared.
- Start accepted in cycle t → busy_o=1 and state FILL/DONE at t+1.
- Element completing a word in cycle t → vrf_we_o=1 at t+1; grant in cycle g → FILL (elem_ready_o=1) or DONE at g+1.
- Best-case throughput (gnt tied high): EPW elements + 1 write cycle per word.
- vrf_gnt_i ignored when vrf_we_o=0.
- done_o high exactly one cycle; busy_o drops the cycle after.
- rst_i mid-operation: next cycle all outputs at reset values, partial word discarded, no write issued.

## Test plan

- VLEN=128, vd=2, SEW8, vl=5, gnt=1, elements 0x11..0x15 -> write addr 8 data 0x14131211 be 1111, then addr 9 data 0x00000015 be 0001, done_o, err_o=0.
- SEW32, vd=0, vl=3, gnt delayed 2 cycles each -> addrs 0,1,2 be 1111, we/addr/data stable while waiting, elem_ready_o=0 during WRITE.
- SEW16, vl=0 -> done_o at start+1, no vrf_we_o, err_o=0; SEW16 vl=3 data 0xAAAA,0xBBBB,0xCCCC -> 0xBBBBAAAA be 1111, 0x0000CCCC be 0011.
- vsew_i=3'b011 with vl=4 -> done_o at start+1 with err_o=1, no writes, elem_ready_o never high.
- vd=31, SEW32, vl=8 -> addrs 124,125,126,127,0,1,2,3.
- rst_i asserted in WRITE while gnt low -> next cycle vrf_we_o=0, busy_o=0; new start after reset proceeds normally; start_i pulsed while busy ignored.
